reset_sequencer: RTL
====================

# reset_sequencer

Sequences ordered release of NUM_STAGES block resets from a single clock domain after power-on or a software reset request. Stages release one at a time; each waits for its per-stage acknowledge before the next stage releases. A missing acknowledge raises a fault and re-asserts every stage. The block sits above the per-domain reset synchronizers: each rst_out bit drives one downstream domain's reset input, and stage_ack is that domain's "out of reset" indication, brought back into clk.

## Interface
- NUM_STAGES, 4, number of sequenced reset outputs (1..16)
- HOLD_CYCLES, 16, cycles all resets stay asserted after entry to ASSERT (>=1)
- STAGE_DELAY, 8, cycles from stage k acknowledge to stage k+1 release (>=1)
- TIMEOUT, 255, maximum cycles to wait for a stage acknowledge (>=1)
- clk  input  1  single system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- sw_rst_req  input  1  software reset request; level-sampled each edge
- stage_ack  input  NUM_STAGES  per-stage "released and ready"; already synchronous to clk
- rst_out  output  NUM_STAGES  active-high reset to each stage, registered
- busy  output  1  sequence in progress (ASSERT/RELEASE/WAIT_ACK/GAP)
- done  output  1  all stages released and acknowledged
- fault  output  1  acknowledge timeout occurred
- fault_stage  output  max(1,$clog2(NUM_STAGES))  index of stage that timed out

## Operation
- Reset values (rst high at an edge): state=ASSERT, rst_out=all 1, busy=1, done=0, fault=0, fault_stage=0, stage index k=0, counter=0.
- States:
  - ASSERT: rst_out=all 1; count HOLD_CYCLES edges, then deassert rst_out[0], k=0, go WAIT_ACK.
  - WAIT_ACK: stage_ack[k] is sampled from the edge after release onward.
    - If high and k<NUM_STAGES-1: go GAP.
    - If high and k==NUM_STAGES-1: go RUN.
    - If TIMEOUT edges elapse without ack: go FAULT.
  - GAP: count STAGE_DELAY edges, then deassert rst_out[k+1], k=k+1, go WAIT_ACK.
  - RUN: done=1, busy=0. stage_ack changes are ignored.
  - FAULT: rst_out=all 1, fault=1, fault_stage=k, busy=0, done=0. Stays in FAULT until sw_rst_req or rst.
- Once a stage is released, it stays released until ASSERT or FAULT. Released stages are always the contiguous low bits of rst_out.
- sw_rst_req high at an edge, in any state: next state is ASSERT; rst_out=all 1, done=0, fault=0, busy=1, counter restarts. In ASSERT this restarts the hold count. fault_stage keeps its value.
- Priority at any edge, highest first: rst, sw_rst_req, timeout, ack, counter expiry.
- Counter width: $clog2(max(HOLD_CYCLES,STAGE_DELAY,TIMEOUT)+1). The counter saturates and never wraps.

## Timing
- Edge numbering: edge 1 is the first edge with rst low.
- rst_out[0] falls at edge HOLD_CYCLES.
- Ack sampled high at edge A: rst_out[k+1] falls at edge A+STAGE_DELAY.
- Last-stage ack sampled high at edge A: done=1 and busy=0 at edge A.
- Stage k released at edge R with no ack: FAULT outputs appear at edge R+TIMEOUT.
- Minimum ack latency: 1 cycle, i.e. an ack held high is sampled at R+1.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- A shared defines include, reset_seq_defs.vh, holds:
  - state encodings: ASSERT, WAIT_ACK, GAP, RUN, FAULT
  - the counter-width helper
- One sub-module, reset_seq_timer: a loadable saturating down-counter with a zero flag. It is reused for the hold, gap and timeout intervals.
- Top level contains the FSM, stage index and output registers.

## Test plan
Common setup: NUM_STAGES=3, HOLD_CYCLES=4, STAGE_DELAY=2, TIMEOUT=8.
1. Nominal sequence: rst high 3 cycles, then low; stage_ack=3'b111 throughout.
   -> rst_out=111 until edge 4, 110 at edge 4, 100 at edge 7, 000 at edge 10; done=1, busy=0 at edge 11.
2. Timeout: as scenario 1 but stage_ack[1]=0.
   -> rst_out=100 at edge 7; at edge 15, rst_out=111, fault=1, fault_stage=1, busy=0, done=0. Outputs are stable while held.
3. Software reset from RUN: sw_rst_req pulsed 1 cycle at edge S after done.
   -> at edge S, rst_out=111, done=0, busy=1; rst_out[0] falls at S+4; done returns at S+11.
4. Priority collision: sw_rst_req and stage_ack[0] both rise for the same edge in WAIT_ACK.
   -> next state is ASSERT, rst_out=111, no GAP entered.
5. Reset mid-operation: rst asserted for 1 edge during GAP after stage 0 is released.
   -> at that edge, every output returns to its reset value; the sequence restarts from edge 1 timing.
6. Fault recovery: from scenario 2's FAULT, set stage_ack=111 and pulse sw_rst_req.
   -> fault=0 at the request edge; the full sequence completes with done=1 11 edges later.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the reset sequencer: FSM state
// encodings plus the stage-index and interval-counter width functions.
package reset_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_ASSERT   = 3'd0,
      ST_WAIT_ACK = 3'd1,
      ST_GAP      = 3'd2,
      ST_RUN      = 3'd3,
      ST_FAULT    = 3'd4
   } state_e;

   // Stage index width; a single-stage build still carries a 1-bit index.
   function automatic int unsigned idx_width(input int unsigned n);
      if (n <= 32'd1) return 32'd1;
      return $clog2(n);
   endfunction

   // One shared counter covers hold, gap and timeout, so size it for the longest.
   function automatic int unsigned cnt_width(input int unsigned hold,
                                             input int unsigned gap,
                                             input int unsigned tmo);
      int unsigned m;
      m = hold;
      if (gap > m) m = gap;
      if (tmo > m) m = tmo;
      return $clog2(m + 32'd1);
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer (master) and the
// downstream reset domains plus software request source (slave).
interface reset_sequencer_if
   import reset_sequencer_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 4
);

   localparam int unsigned IDX_W = idx_width(NUM_STAGES);

   logic                  sw_rst_req;
   logic [NUM_STAGES-1:0] stage_ack;
   logic [NUM_STAGES-1:0] rst_out;
   logic                  busy;
   logic                  done;
   logic                  fault;
   logic [IDX_W-1:0]      fault_stage;

   modport master (
      input  sw_rst_req,
      input  stage_ack,
      output rst_out,
      output busy,
      output done,
      output fault,
      output fault_stage
   );

   modport slave (
      output sw_rst_req,
      output stage_ack,
      input  rst_out,
      input  busy,
      input  done,
      input  fault,
      input  fault_stage
   );

endinterface

// File: rtl/reset_sequencer_timer.sv
// Loadable saturating down-counter with a zero flag; one instance times the
// hold, inter-stage gap and acknowledge timeout intervals in turn.
module reset_seq_timer #(
   parameter int unsigned      CNT_W   = 8,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   // Holds at zero rather than wrapping, so an expired interval stays expired.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= RST_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES downstream resets in order, waiting for each stage's
// acknowledge; a missing acknowledge re-asserts everything and latches a fault.
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int unsigned NUM_STAGES  = 4,
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned STAGE_DELAY = 8,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic              clk,
   input  logic              rst,
   reset_sequencer_if.master bus
);

   localparam int unsigned IDX_W = idx_width(NUM_STAGES);
   localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, STAGE_DELAY, TIMEOUT);

   // Timer is loaded with N-1 so that expiry lands exactly N edges after the load.
   localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(STAGE_DELAY - 32'd1);
   localparam logic [CNT_W-1:0] TMO_LD  = CNT_W'(TIMEOUT - 32'd1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 32'd1);

   state_e                state_d, state_q;
   logic [IDX_W-1:0]      k_d, k_q;
   logic [NUM_STAGES-1:0] rst_out_d, rst_out_q;
   logic                  busy_d, busy_q;
   logic                  done_d, done_q;
   logic                  fault_d, fault_q;
   logic [IDX_W-1:0]      fault_stage_d, fault_stage_q;

   logic                  tmr_load;
   logic [CNT_W-1:0]      tmr_load_val;
   logic                  tmr_zero;
   logic [IDX_W-1:0]      nxt_idx;

   reset_seq_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (HOLD_LD)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d       = state_q;
      k_d           = k_q;
      rst_out_d     = rst_out_q;
      busy_d        = busy_q;
      done_d        = done_q;
      fault_d       = fault_q;
      fault_stage_d = fault_stage_q;
      tmr_load      = 1'b0;
      tmr_load_val  = HOLD_LD;
      nxt_idx       = k_q + 1'b1;

      if (bus.sw_rst_req) begin
         // Software request overrides everything but rst; fault_stage is kept for diagnosis.
         state_d      = ST_ASSERT;
         rst_out_d    = '1;
         busy_d       = 1'b1;
         done_d       = 1'b0;
         fault_d      = 1'b0;
         tmr_load     = 1'b1;
         tmr_load_val = HOLD_LD;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               if (tmr_zero) begin
                  state_d      = ST_WAIT_ACK;
                  k_d          = '0;
                  rst_out_d[0] = 1'b0;
                  tmr_load     = 1'b1;
                  tmr_load_val = TMO_LD;
               end
            end
            ST_WAIT_ACK: begin
               // Timeout outranks an acknowledge arriving on the same edge.
               if (tmr_zero) begin
                  state_d       = ST_FAULT;
                  rst_out_d     = '1;
                  busy_d        = 1'b0;
                  done_d        = 1'b0;
                  fault_d       = 1'b1;
                  fault_stage_d = k_q;
               end else if (bus.stage_ack[k_q]) begin
                  if (k_q == LAST_IDX) begin
                     state_d = ST_RUN;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     state_d      = ST_GAP;
                     tmr_load     = 1'b1;
                     tmr_load_val = GAP_LD;
                  end
               end
            end
            ST_GAP: begin
               if (tmr_zero) begin
                  state_d            = ST_WAIT_ACK;
                  k_d                = nxt_idx;
                  rst_out_d[nxt_idx] = 1'b0;
                  tmr_load           = 1'b1;
                  tmr_load_val       = TMO_LD;
               end
            end
            ST_RUN: begin
            end
            ST_FAULT: begin
            end
            default: begin
               state_d   = ST_ASSERT;
               rst_out_d = '1;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               tmr_load  = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_ASSERT;
         k_q           <= '0;
         rst_out_q     <= '1;
         busy_q        <= 1'b1;
         done_q        <= 1'b0;
         fault_q       <= 1'b0;
         fault_stage_q <= '0;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         rst_out_q     <= rst_out_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         fault_q       <= fault_d;
         fault_stage_q <= fault_stage_d;
      end
   end

   assign bus.rst_out     = rst_out_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.fault       = fault_q;
   assign bus.fault_stage = fault_stage_q;

endmodule
